// File: rtl/vx_tcu_fedp_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// vx_tcu_fedp_ctrl_pkg
//
// Shared TCU definitions used by the FEDP issue/writeback controller and its
// step tracker:
//   - FEDP source format encodings (FMT_FP16, FMT_BF16)
//   - accumulator-slot count and ID width shared by controller and tracker
//   - tracker entry struct {valid, acc_id, last}
// ---------------------------------------------------------------------------
package vx_tcu_fedp_ctrl_pkg;

    // FEDP source format encodings carried on req_fmt_s / fedp_fmt_s
    localparam logic [2:0] FMT_FP16 = 3'd2;
    localparam logic [2:0] FMT_BF16 = 3'd3;

    // Accumulator slot count; the tracker entry stores an ID of this width,
    // so the controller's NUM_ACC must match it.
    localparam int TCU_NUM_ACC = 4;
    localparam int TCU_ACCW    = $clog2(TCU_NUM_ACC);

    // One in-flight FEDP step as seen by the tracker
    typedef struct packed {
        logic                valid;
        logic [TCU_ACCW-1:0] acc_id;
        logic                last;
    } trk_entry_t;

endpackage

// File: rtl/vx_tcu_fedp_ctrl_tracker.sv
// ---------------------------------------------------------------------------
// vx_tcu_fedp_ctrl_tracker
//
// LATENCY-deep shift register that mirrors the FEDP pipeline. Each stage
// holds the {valid, acc_id, last} tag of the step occupying the matching
// FEDP stage. The register only advances when the FEDP advances, so the
// tail entry always describes the value currently on fedp_d_val.
//
// Ports:
//   clk      in   clock
//   reset    in   asynchronous active-high reset; flushes every stage
//   enable   in   advance (same as the FEDP enable)
//   in_entry in   tag entering stage 0 (valid=0 for a bubble)
//   tail     out  tag of the step at the FEDP output
// ---------------------------------------------------------------------------
module vx_tcu_fedp_ctrl_tracker
    import vx_tcu_fedp_ctrl_pkg::*;
#(
    parameter int LATENCY = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  trk_entry_t in_entry,
    output trk_entry_t tail
);

    trk_entry_t stages [LATENCY];

    // Shift every stage forward only on enabled cycles; a reset flushes all
    // stages so any steps left in the FEDP are ignored afterwards.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < LATENCY; i++) begin
                stages[i] <= '0;
            end
        end else if (enable) begin
            stages[0] <= in_entry;
            for (int i = 1; i < LATENCY; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    assign tail = stages[LATENCY-1];

endmodule

// File: rtl/vx_tcu_fedp_ctrl.sv
// ---------------------------------------------------------------------------
// vx_tcu_fedp_ctrl
//
// Issue and writeback controller for the tensor-core fused dot-product
// (FEDP) pipeline. Accepts step requests, forwards operands into the FEDP,
// chains K-accumulation through an accumulator file (with same-cycle
// writeback bypass), tracks in-flight steps, and returns final
// accumulations through a single-entry response register.
//
// Ports:
//   clk, reset                    clock, async active-high reset
//   req_valid / req_ready         step request handshake
//   req_fmt_s, req_a_row,
//   req_b_col, req_c_val          step operands and format
//   req_acc_id, req_first,
//   req_last                      accumulator slot and chain markers
//   fedp_enable                   FEDP pipeline advance
//   fedp_fmt_s, fedp_a_row,
//   fedp_b_col, fedp_c_val        FEDP operand inputs
//   fedp_d_val                    FEDP result (from the tail stage)
//   rsp_valid / rsp_ready         response handshake
//   rsp_acc_id, rsp_d_val         returned slot and final value
// ---------------------------------------------------------------------------
module vx_tcu_fedp_ctrl
    import vx_tcu_fedp_ctrl_pkg::*;
#(
    parameter  int N       = 2,
    parameter  int XLEN    = 32,
    parameter  int LATENCY = 4,
    parameter  int NUM_ACC = TCU_NUM_ACC,
    localparam int ACCW    = $clog2(NUM_ACC)
) (
    input  logic                clk,
    input  logic                reset,

    input  logic                req_valid,
    output logic                req_ready,
    input  logic [2:0]          req_fmt_s,
    input  logic [N*XLEN-1:0]   req_a_row,
    input  logic [N*XLEN-1:0]   req_b_col,
    input  logic [XLEN-1:0]     req_c_val,
    input  logic [ACCW-1:0]     req_acc_id,
    input  logic                req_first,
    input  logic                req_last,

    output logic                fedp_enable,
    output logic [2:0]          fedp_fmt_s,
    output logic [N*XLEN-1:0]   fedp_a_row,
    output logic [N*XLEN-1:0]   fedp_b_col,
    output logic [XLEN-1:0]     fedp_c_val,
    input  logic [XLEN-1:0]     fedp_d_val,

    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [ACCW-1:0]     rsp_acc_id,
    output logic [XLEN-1:0]     rsp_d_val
);

    trk_entry_t         tail;
    trk_entry_t         issue_entry;
    logic               wb_fire;
    logic               wb_same_id;
    logic               issue;
    logic [NUM_ACC-1:0] busy;
    logic [NUM_ACC-1:0] busy_next;
    logic [XLEN-1:0]    acc [NUM_ACC];

    // The pipe only freezes when a final result reaches the tail while the
    // response register is still held; draining and refilling it in the
    // same cycle keeps the pipe moving.
    assign fedp_enable = !(tail.valid && tail.last && rsp_valid && !rsp_ready);
    assign wb_fire     = tail.valid && fedp_enable;
    assign wb_same_id  = wb_fire && (tail.acc_id == req_acc_id);

    // A busy slot is still accepted when its producer writes back this
    // cycle, because the result is bypassed straight into fedp_c_val.
    assign req_ready = fedp_enable && !(busy[req_acc_id] && !wb_same_id);
    assign issue     = req_valid && req_ready;

    assign fedp_fmt_s = req_fmt_s;

    // Operand forwarding: zero when nothing issues. A first step takes the
    // caller's initial value even if a writeback to the same slot fires.
    always_comb begin
        fedp_a_row = '0;
        fedp_b_col = '0;
        fedp_c_val = '0;
        if (issue) begin
            fedp_a_row = req_a_row;
            fedp_b_col = req_b_col;
            if (req_first) begin
                fedp_c_val = req_c_val;
            end else if (wb_same_id) begin
                fedp_c_val = fedp_d_val;
            end else begin
                fedp_c_val = acc[req_acc_id];
            end
        end
    end

    always_comb begin
        issue_entry        = '0;
        issue_entry.valid  = issue;
        issue_entry.acc_id = req_acc_id;
        issue_entry.last   = req_last;
    end

    vx_tcu_fedp_ctrl_tracker #(
        .LATENCY (LATENCY)
    ) tracker (
        .clk      (clk),
        .reset    (reset),
        .enable   (fedp_enable),
        .in_entry (issue_entry),
        .tail     (tail)
    );

    // Scoreboard next state: the clear from writeback is applied first so
    // that a same-slot issue in the same cycle leaves the slot busy.
    always_comb begin
        busy_next = busy;
        if (wb_fire) begin
            busy_next[tail.acc_id] = 1'b0;
        end
        if (issue) begin
            busy_next[req_acc_id] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    // Accumulator file: every writeback records the partial sum so the next
    // step of the chain can read it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_ACC; i++) begin
                acc[i] <= '0;
            end
        end else if (wb_fire) begin
            acc[tail.acc_id] <= fedp_d_val;
        end
    end

    // Single-entry response register: a final writeback loads it; otherwise
    // a consumer accept empties it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_valid  <= 1'b0;
            rsp_acc_id <= '0;
            rsp_d_val  <= '0;
        end else if (wb_fire && tail.last) begin
            rsp_valid  <= 1'b1;
            rsp_acc_id <= tail.acc_id;
            rsp_d_val  <= fedp_d_val;
        end else if (rsp_ready) begin
            rsp_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vx_tcu_fedp_ctrl.sv
// ---------------------------------------------------------------------------
// tb_vx_tcu_fedp_ctrl
//
// Bench for the FEDP controller. A behavioural FEDP (real arithmetic,
// LATENCY enabled stages) is attached to the DUT. The reference model keeps
// in-flight steps as a queue of {id, last, age, value}, accumulator values
// per slot and one pending response, and predicts stall, ready, operand
// selection and responses each cycle.
// ---------------------------------------------------------------------------
module tb_vx_tcu_fedp_ctrl;
    import vx_tcu_fedp_ctrl_pkg::*;

    localparam int N    = 2;
    localparam int XLEN = 32;
    localparam int LAT  = 4;
    localparam int NACC = 4;
    localparam int ACCW = 2;

    logic                clk = 1'b0;
    logic                reset;
    logic                req_valid;
    logic                req_ready;
    logic [2:0]          req_fmt_s;
    logic [N*XLEN-1:0]   req_a_row;
    logic [N*XLEN-1:0]   req_b_col;
    logic [XLEN-1:0]     req_c_val;
    logic [ACCW-1:0]     req_acc_id;
    logic                req_first;
    logic                req_last;
    logic                fedp_enable;
    logic [2:0]          fedp_fmt_s;
    logic [N*XLEN-1:0]   fedp_a_row;
    logic [N*XLEN-1:0]   fedp_b_col;
    logic [XLEN-1:0]     fedp_c_val;
    logic [XLEN-1:0]     fedp_d_val;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [ACCW-1:0]     rsp_acc_id;
    logic [XLEN-1:0]     rsp_d_val;

    always #5 clk = ~clk;

    vx_tcu_fedp_ctrl #(
        .N       (N),
        .XLEN    (XLEN),
        .LATENCY (LAT),
        .NUM_ACC (NACC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_fmt_s   (req_fmt_s),
        .req_a_row   (req_a_row),
        .req_b_col   (req_b_col),
        .req_c_val   (req_c_val),
        .req_acc_id  (req_acc_id),
        .req_first   (req_first),
        .req_last    (req_last),
        .fedp_enable (fedp_enable),
        .fedp_fmt_s  (fedp_fmt_s),
        .fedp_a_row  (fedp_a_row),
        .fedp_b_col  (fedp_b_col),
        .fedp_c_val  (fedp_c_val),
        .fedp_d_val  (fedp_d_val),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_acc_id  (rsp_acc_id),
        .rsp_d_val   (rsp_d_val)
    );

    // Float helpers (exact for the small values used here)
    function automatic real fp16ToReal(input logic [15:0] h);
        int  e;
        int  m;
        real r;
        e = int'(h[14:10]);
        m = int'(h[9:0]);
        if (e == 0) r = m * (2.0 ** -24);
        else        r = (1.0 + m / 1024.0) * (2.0 ** (e - 15));
        return h[15] ? -r : r;
    endfunction

    function automatic real fp32ToReal(input logic [31:0] f);
        int  e;
        int  m;
        real r;
        e = int'(f[30:23]);
        m = int'(f[22:0]);
        if (e == 0) r = m * (2.0 ** -149);
        else        r = (1.0 + m / 8388608.0) * (2.0 ** (e - 127));
        return f[31] ? -r : r;
    endfunction

    function automatic logic [31:0] realToFp32(input real r);
        logic [63:0] d;
        logic [10:0] e;
        if (r == 0.0) return 32'h0;
        d = $realtobits(r);
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic real elemToReal(input logic [2:0] fmt, input logic [15:0] h);
        if (fmt == FMT_BF16) return fp32ToReal({h, 16'h0000});
        return fp16ToReal(h);
    endfunction

    function automatic real dotp(input logic [2:0] fmt, input logic [N*XLEN-1:0] a,
                                 input logic [N*XLEN-1:0] b);
        real s;
        s = 0.0;
        for (int i = 0; i < 2*N; i++) begin
            s = s + elemToReal(fmt, a[i*16 +: 16]) * elemToReal(fmt, b[i*16 +: 16]);
        end
        return s;
    endfunction

    // Behavioural FEDP: d = c + sum(a*b), LAT enabled cycles later
    logic [XLEN-1:0] pipe [LAT];

    always @(posedge clk) begin
        if (fedp_enable) begin
            pipe[0] <= realToFp32(fp32ToReal(fedp_c_val) + dotp(fedp_fmt_s, fedp_a_row, fedp_b_col));
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign fedp_d_val = pipe[LAT-1];

    // Reference model state
    typedef struct {
        int  id;
        bit  last;
        int  age;
        real val;
    } flight_t;

    flight_t     fl[$];
    real         chain [NACC];
    bit          mrspV;
    int          mrspId;
    logic [31:0] mrspBits;

    int total;
    int bad;
    int dutRsp;
    bit lastIssue;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic modelClear();
        fl.delete();
        for (int i = 0; i < NACC; i++) chain[i] = 0.0;
        mrspV    = 1'b0;
        mrspId   = 0;
        mrspBits = '0;
    endtask

    // One cycle: drive at the falling edge, check 1 time unit later, then
    // advance the model by what the coming rising edge must do.
    task automatic applyStimulus(input bit v, input logic [2:0] fmt,
                                 input logic [N*XLEN-1:0] a, input logic [N*XLEN-1:0] b,
                                 input logic [31:0] c, input int id,
                                 input bit first, input bit last, input bit rr);
        bit      tailV;
        bit      expEn;
        bit      expRdy;
        bit      blocked;
        real     prev;
        real     cin;
        flight_t f;
        @(negedge clk);
        req_valid  = v;
        req_fmt_s  = fmt;
        req_a_row  = a;
        req_b_col  = b;
        req_c_val  = c;
        req_acc_id = ACCW'(id);
        req_first  = first;
        req_last   = last;
        rsp_ready  = rr;
        #1;
        tailV   = (fl.size() > 0) && (fl[0].age == LAT-1);
        expEn   = !(tailV && fl[0].last && mrspV && !rr);
        blocked = 1'b0;
        foreach (fl[k]) if (fl[k].id == id && !(k == 0 && tailV)) blocked = 1'b1;
        expRdy  = expEn && !blocked;
        checkOutput("fedp_enable", 64'(fedp_enable), 64'(expEn));
        checkOutput("req_ready", 64'(req_ready), 64'(expRdy));
        checkOutput("rsp_valid", 64'(rsp_valid), 64'(mrspV));
        if (mrspV) begin
            checkOutput("rsp_acc_id", 64'(rsp_acc_id), 64'(mrspId));
            checkOutput("rsp_d_val", 64'(rsp_d_val), 64'(mrspBits));
        end
        if (rsp_valid && rr) dutRsp++;
        lastIssue = v && expRdy;
        prev = 0.0;
        cin  = 0.0;
        if (lastIssue) begin
            prev = (tailV && fl[0].id == id) ? fl[0].val : chain[id];
            cin  = first ? fp32ToReal(c) : prev;
            checkOutput("fedp_c_val", 64'(fedp_c_val), first ? 64'(c) : 64'(realToFp32(prev)));
            checkOutput("fedp_a_row", 64'(fedp_a_row), 64'(a));
        end else begin
            checkOutput("fedp_c_val_idle", 64'(fedp_c_val), 64'h0);
        end
        if (mrspV && rr) mrspV = 1'b0;
        if (expEn && tailV) begin
            f = fl.pop_front();
            chain[f.id] = f.val;
            if (f.last) begin
                mrspV    = 1'b1;
                mrspId   = f.id;
                mrspBits = realToFp32(f.val);
            end
        end
        if (expEn) foreach (fl[k]) fl[k].age++;
        if (lastIssue) begin
            f.id   = id;
            f.last = last;
            f.age  = 0;
            f.val  = fp32ToReal(realToFp32(cin + dotp(fmt, a, b)));
            fl.push_back(f);
        end
    endtask

    task automatic idle(input int n, input bit rr);
        repeat (n) applyStimulus(1'b0, FMT_FP16, '0, '0, 32'h0, 0, 1'b0, 1'b0, rr);
    endtask

    task automatic sendReq(input logic [2:0] fmt, input logic [N*XLEN-1:0] a,
                           input logic [N*XLEN-1:0] b, input logic [31:0] c, input int id,
                           input bit first, input bit last, input bit rr, output int waited);
        waited = 0;
        for (int t = 0; t < 40; t++) begin
            applyStimulus(1'b1, fmt, a, b, c, id, first, last, rr);
            if (lastIssue) return;
            waited++;
        end
        checkOutput("req_accept_timeout", 64'(req_ready), 64'h1);
    endtask

    localparam logic [N*XLEN-1:0] A_ONES = {32'h3C003C00, 32'h3C003C00};
    localparam logic [N*XLEN-1:0] B_TWOS = {32'h40004000, 32'h40004000};

    logic [15:0] fp16Tab [4] = '{16'h3C00, 16'h4000, 16'h3800, 16'h4200};
    logic [15:0] bf16Tab [4] = '{16'h3F80, 16'h4000, 16'h3F00, 16'h4040};
    logic [31:0] cTab    [4] = '{32'h00000000, 32'h3F800000, 32'h40000000, 32'h40400000};
    bit          open    [NACC];

    initial begin
        int               w;
        bit               v;
        int               id;
        bit               first;
        bit               last;
        bit               rr;
        logic [2:0]       fmt;
        logic [N*XLEN-1:0] a;
        logic [N*XLEN-1:0] b;

        total = 0;
        bad   = 0;
        modelClear();
        reset     = 1'b1;
        req_valid = 1'b0;
        req_fmt_s = FMT_FP16;
        req_a_row = '0;
        req_b_col = '0;
        req_c_val = '0;
        req_acc_id = '0;
        req_first = 1'b0;
        req_last  = 1'b0;
        rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("reset_rsp_valid", 64'(rsp_valid), 64'h0);
        checkOutput("reset_rsp_d_val", 64'(rsp_d_val), 64'h0);
        checkOutput("reset_rsp_acc_id", 64'(rsp_acc_id), 64'h0);
        checkOutput("reset_enable", 64'(fedp_enable), 64'h1);
        checkOutput("reset_req_ready", 64'(req_ready), 64'h1);
        reset = 1'b0;

        // Test 1: single step, 1*2*4 + 1.0 = 9.0, result in cycle LAT+1
        $display("[TB] single step");
        sendReq(FMT_FP16, A_ONES, B_TWOS, 32'h3F800000, 0, 1'b1, 1'b1, 1'b1, w);
        idle(LAT + 1, 1'b1);
        checkOutput("t1_rsp_valid", 64'(rsp_valid), 64'h1);
        checkOutput("t1_rsp_d_val", 64'(rsp_d_val), 64'h41100000);
        checkOutput("t1_rsp_acc_id", 64'(rsp_acc_id), 64'h0);
        idle(2, 1'b1);

        // Test 2: three-step chain on ID 1 -> 24.0, one response
        $display("[TB] chain on one id");
        dutRsp = 0;
        sendReq(FMT_FP16, A_ONES, B_TWOS, 32'h0, 1, 1'b1, 1'b0, 1'b1, w);
        sendReq(FMT_FP16, A_ONES, B_TWOS, 32'h0, 1, 1'b0, 1'b0, 1'b1, w);
        checkOutput("t2_wait_step2", 64'(w), 64'(LAT - 1));
        sendReq(FMT_FP16, A_ONES, B_TWOS, 32'h0, 1, 1'b0, 1'b1, 1'b1, w);
        checkOutput("t2_wait_step3", 64'(w), 64'(LAT - 1));
        idle(LAT + 2, 1'b1);
        checkOutput("t2_rsp_count", 64'(dutRsp), 64'h1);

        // Test 3: interleaved IDs, no stalls, 8/9/10/11
        $display("[TB] interleaved ids");
        dutRsp = 0;
        for (int i = 0; i < 4; i++) begin
            sendReq(FMT_FP16, A_ONES, B_TWOS, cTab[i], i, 1'b1, 1'b1, 1'b1, w);
            checkOutput("t3_no_stall", 64'(w), 64'h0);
        end
        idle(LAT + 3, 1'b1);
        checkOutput("t3_rsp_count", 64'(dutRsp), 64'h4);

        // Test 4: same traffic with the response port held off
        $display("[TB] backpressure");
        dutRsp = 0;
        for (int i = 0; i < 4; i++) begin
            sendReq(FMT_FP16, A_ONES, B_TWOS, cTab[i], i, 1'b1, 1'b1, 1'b0, w);
        end
        idle(2, 1'b0);
        checkOutput("t4_stall_enable", 64'(fedp_enable), 64'h0);
        checkOutput("t4_stall_ready", 64'(req_ready), 64'h0);
        idle(5, 1'b0);
        idle(LAT + 6, 1'b1);
        checkOutput("t4_rsp_count", 64'(dutRsp), 64'h4);

        // Test 5: a first step on a busy slot waits and ignores the bypass
        $display("[TB] busy on first");
        sendReq(FMT_FP16, A_ONES, B_TWOS, 32'h3F800000, 2, 1'b1, 1'b0, 1'b1, w);
        sendReq(FMT_FP16, A_ONES, B_TWOS, 32'h40000000, 2, 1'b1, 1'b1, 1'b1, w);
        checkOutput("t5_wait", 64'(w), 64'(LAT - 1));
        idle(LAT + 2, 1'b1);

        // Test 6: reset with a held response and three steps in flight
        $display("[TB] reset mid-flight");
        sendReq(FMT_FP16, A_ONES, B_TWOS, 32'h0, 0, 1'b1, 1'b1, 1'b0, w);
        idle(LAT + 1, 1'b0);
        sendReq(FMT_FP16, A_ONES, B_TWOS, 32'h0, 1, 1'b1, 1'b1, 1'b0, w);
        sendReq(FMT_FP16, A_ONES, B_TWOS, 32'h0, 2, 1'b1, 1'b0, 1'b0, w);
        sendReq(FMT_FP16, A_ONES, B_TWOS, 32'h0, 3, 1'b1, 1'b0, 1'b0, w);
        idle(1, 1'b0);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checkOutput("t6_rsp_valid_async", 64'(rsp_valid), 64'h0);
        modelClear();
        @(negedge clk);
        reset  = 1'b0;
        dutRsp = 0;
        idle(1, 1'b1);
        checkOutput("t6_ready_after", 64'(req_ready), 64'h1);
        idle(2 * LAT, 1'b1);
        checkOutput("t6_no_stale_rsp", 64'(dutRsp), 64'h0);

        // Randomised traffic against the model
        $display("[TB] random traffic");
        for (int i = 0; i < NACC; i++) open[i] = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            v     = ($urandom_range(0, 3) != 0);
            id    = int'($urandom_range(0, NACC - 1));
            first = !open[id] || ($urandom_range(0, 7) == 0);
            last  = ($urandom_range(0, 2) == 0);
            rr    = ($urandom_range(0, 9) < 7);
            fmt   = ($urandom_range(0, 1) == 0) ? FMT_FP16 : FMT_BF16;
            for (int k = 0; k < 2 * N; k++) begin
                a[k*16 +: 16] = (fmt == FMT_BF16) ? bf16Tab[$urandom_range(0, 3)] : fp16Tab[$urandom_range(0, 3)];
                b[k*16 +: 16] = (fmt == FMT_BF16) ? bf16Tab[$urandom_range(0, 3)] : fp16Tab[$urandom_range(0, 3)];
            end
            applyStimulus(v, fmt, a, b, cTab[$urandom_range(0, 3)], id, first, last, rr);
            if (lastIssue) open[id] = !last;
        end
        idle(3 * LAT + 4, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
